// File: rtl/index2angle.sv
// Converts a scan point index back to a signed start-referenced angle (x10000).
// Uses a serial LSB-first shift-add multiply, then subtracts the 90 degree offset.
module index2angle #(
  parameter logic [31:0] ANGLE_OFFSET = 32'h000DBBA0,
  parameter int          MUL_BITS     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req,
  input  logic [MUL_BITS-1:0] i_index,
  input  logic [15:0]         i_angle_reso,
  output logic                o_busy,
  output logic                o_valid,
  output logic                o_err,
  output logic [31:0]         o_angle
);

  // state     | meaning
  // ST_IDLE   | waiting for i_req; inputs latched on accept
  // ST_CHECK  | range check against the reso-dependent index limit
  // ST_MUL    | one shift-add iteration per cycle, MUL_BITS cycles
  // ST_OFFSET | subtract ANGLE_OFFSET, publish result and strobe o_valid
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;
  localparam logic [1:0] ST_OFFSET = 2'd3;

  localparam int CNT_W = $clog2(MUL_BITS + 1);

  logic [1:0]          r_state;
  logic [MUL_BITS-1:0] r_index;
  logic [15:0]         r_reso;
  logic [31:0]         r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_valid;
  logic                r_err;
  logic [31:0]         r_angle;

  logic [MUL_BITS-1:0] w_limit;
  logic                w_range_err;
  logic [MUL_BITS-1:0] w_index_shr;
  logic                w_bit;
  logic [31:0]         w_addend;
  logic                w_last;

  // Unknown resolutions fall back to the 0.1 degree limit.
  always_comb begin
    w_limit = MUL_BITS'(3600);
    case (r_reso)
      16'd1200: w_limit = MUL_BITS'(3000);
      16'd1000: w_limit = MUL_BITS'(3600);
      16'd500:  w_limit = MUL_BITS'(7200);
      default:  w_limit = MUL_BITS'(3600);
    endcase
  end

  assign w_range_err = (r_index > w_limit) || (r_reso == 16'd0);
  assign w_index_shr = r_index >> r_cnt;
  assign w_bit       = w_index_shr[0];
  assign w_addend    = 32'(r_reso) << r_cnt;
  assign w_last      = (r_cnt == CNT_W'(MUL_BITS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      r_reso  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_angle <= 32'hFFF24460;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_index <= i_index;
            r_reso  <= i_angle_reso;
            r_err   <= 1'b0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_range_err) begin
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (w_bit) r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= ST_OFFSET;
        end
        ST_OFFSET: begin
          r_angle <= r_acc - ANGLE_OFFSET;
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_angle = r_angle;

endmodule
